// File: rtl/parking_pkg.sv
// Shared constants for the parking occupancy counter: default sizing and
// the active-low 7-segment digit encodings (segment order g..a).
package parking_pkg;

  localparam int CAPACITY_DEF      = 60;
  localparam int FILTER_CYCLES_DEF = 4;
  localparam int CNT_W_DEF         = 7;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal digit to segment pattern; out-of-range codes blank the digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sensor_filter.sv
// Debounce for one raw asynchronous sensor: two-flop synchroniser followed by
// a stable counter. The filtered level only follows the synchronised input
// once it has disagreed for FILTER_CYCLES consecutive cycles.
module sensor_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sensor_i,
  output logic level_o
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser, counter and accepted level; reset means "sensor inactive".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/parking_occupancy_counter.sv
// Lot occupancy tracker: debounces the gate-pass and exit-lane sensors,
// turns their rising edges into entry/exit events, keeps a saturating
// occupancy count with sticky error flags and shows free spaces on two
// active-low 7-segment digits.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY      = CAPACITY_DEF,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             gate_open,
  input  logic             sensor_exit,
  input  logic             lane_out,
  input  logic             err_clr,
  output logic [CNT_W-1:0] occupancy,
  output logic [CNT_W-1:0] free_spaces,
  output logic             lot_full,
  output logic             entry_allow,
  output logic             car_in_pulse,
  output logic             car_out_pulse,
  output logic             overflow_err,
  output logic             underflow_err,
  output logic [6:0]       HEX_1,
  output logic [6:0]       HEX_0
);

  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
  localparam logic [3:0]       CAP_TENS = 4'(CAPACITY / 10);
  localparam logic [3:0]       CAP_UNITS = 4'(CAPACITY % 10);
  localparam logic [6:0]       HEX1_RST = (CAP_TENS == 4'd0) ? SEG_BLANK : seg_encode(CAP_TENS);
  localparam logic [6:0]       HEX0_RST = seg_encode(CAP_UNITS);

  logic in_level, out_level;
  logic in_prev_q, out_prev_q;
  logic in_evt, out_evt;

  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] free_q, free_d;
  logic             full_q, allow_q;
  logic             in_pulse_q, out_pulse_q;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_set, unf_set;
  logic [3:0]       tens, units;
  logic [6:0]       hex1_q, hex1_d, hex0_q, hex0_d;

  sensor_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_in (
    .clk      (clk),
    .reset_n  (reset_n),
    .sensor_i (sensor_exit),
    .level_o  (in_level)
  );

  sensor_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_out (
    .clk      (clk),
    .reset_n  (reset_n),
    .sensor_i (lane_out),
    .level_o  (out_level)
  );

  // An entry only counts if the gate is open in the cycle the filtered edge appears.
  assign in_evt  = in_level & ~in_prev_q & gate_open;
  assign out_evt = out_level & ~out_prev_q;

  // Saturating occupancy update; coincident entry and exit cancel without error.
  always_comb begin
    occ_d   = occ_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case ({in_evt, out_evt})
      2'b10: begin
        if (occ_q < CAP) occ_d = occ_q + CNT_W'(1);
        else             ovf_set = 1'b1;
      end
      2'b01: begin
        if (occ_q != '0) occ_d = occ_q - CNT_W'(1);
        else             unf_set = 1'b1;
      end
      default: occ_d = occ_q;
    endcase
    free_d = CAP - occ_d;
    // A new error beats a simultaneous clear.
    ovf_d  = ovf_set | (ovf_q & ~err_clr);
    unf_d  = unf_set | (unf_q & ~err_clr);
  end

  // Decimal split of the already-registered free count for the display.
  always_comb begin
    tens   = 4'(free_q / CNT_W'(10));
    units  = 4'(free_q % CNT_W'(10));
    hex1_d = (tens == 4'd0) ? SEG_BLANK : seg_encode(tens);
    hex0_d = seg_encode(units);
  end

  // Event history, counters, flags and display registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_prev_q   <= 1'b0;
      out_prev_q  <= 1'b0;
      occ_q       <= '0;
      free_q      <= CAP;
      full_q      <= 1'b0;
      allow_q     <= 1'b1;
      in_pulse_q  <= 1'b0;
      out_pulse_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      hex1_q      <= HEX1_RST;
      hex0_q      <= HEX0_RST;
    end else begin
      in_prev_q   <= in_level;
      out_prev_q  <= out_level;
      occ_q       <= occ_d;
      free_q      <= free_d;
      full_q      <= (occ_d == CAP);
      allow_q     <= (occ_d != CAP);
      in_pulse_q  <= in_evt;
      out_pulse_q <= out_evt;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      hex1_q      <= hex1_d;
      hex0_q      <= hex0_d;
    end
  end

  assign occupancy     = occ_q;
  assign free_spaces   = free_q;
  assign lot_full      = full_q;
  assign entry_allow   = allow_q;
  assign car_in_pulse  = in_pulse_q;
  assign car_out_pulse = out_pulse_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
  assign HEX_1         = hex1_q;
  assign HEX_0         = hex0_q;

endmodule

// File: doc/parking_occupancy_counter.md
Name: parking_occupancy_counter

Overview:
- Sits directly downstream of the parking gate FSM and consumes its GREEN_LED level (gate open) plus the raw gate and exit-lane sensors.
- Counts cars that pass the open gate and cars that leave through the exit lane, then maintains lot occupancy, a full flag and sticky error flags.
- Drives two active-low 7-segment digits that show the free spaces.
- Its entry_allow output feeds back to gate logic so that entry is refused when the lot is full.

Parameters:
- CAPACITY, 60, number of parking spaces; legal range 1..99.
- FILTER_CYCLES, 4, consecutive stable synchronised samples needed before a sensor level is accepted; legal range ≥1.
- CNT_W, 7, width of the occupancy and free counts; must satisfy 2^CNT_W > CAPACITY.

Ports:
- clk  in  1  block clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- gate_open  in  1  GREEN_LED from the gate FSM; synchronous to clk.
- sensor_exit  in  1  raw gate-pass sensor (the car is crossing the gate); asynchronous.
- lane_out  in  1  raw exit-lane sensor; asynchronous.
- err_clr  in  1  synchronous pulse that clears the sticky error flags.
- occupancy  out  CNT_W  cars currently in the lot.
- free_spaces  out  CNT_W  CAPACITY minus occupancy.
- lot_full  out  1  high when occupancy equals CAPACITY.
- entry_allow  out  1  the inverse of lot_full.
- car_in_pulse  out  1  one-cycle pulse on each counted entry.
- car_out_pulse  out  1  one-cycle pulse on each counted exit.
- overflow_err  out  1  sticky flag: an entry was seen while the lot was full.
- underflow_err  out  1  sticky flag: an exit was seen while the lot was empty.
- HEX_1  out  7  tens digit of free_spaces, active-low segments g..a.
- HEX_0  out  7  units digit of free_spaces, active-low segments g..a.

Behaviour:
- Reset (asynchronous, immediate): occupancy is 0 and free_spaces is CAPACITY; lot_full=0, entry_allow=1, both pulses 0, both errors 0. HEX_1/HEX_0 show CAPACITY (60 gives 0000010 / 1000000). Filter state is cleared to 0 (sensor inactive).
- Sensor filter, one instance per sensor:
  - 2-flop synchroniser, then a stable counter.
  - The filtered level changes only after the synchronised value has differed from it for FILTER_CYCLES consecutive cycles; any bounce resets the counter.
  - A raw level held stable from edge t updates the filtered level at edge t+2+FILTER_CYCLES.
- Event detect:
  - in_evt is the rising edge of the filtered sensor_exit, qualified by gate_open sampled in the same cycle.
  - out_evt is the rising edge of the filtered lane_out.
  - A rising edge on sensor_exit while gate_open=0 is ignored: no count and no error.
- Counter update, registered on the cycle after the event, i.e. edge t+3+FILTER_CYCLES:
  - in_evt only, occupancy<CAPACITY: occupancy +1, car_in_pulse=1.
  - in_evt only, occupancy==CAPACITY: occupancy held, car_in_pulse=1, overflow_err set.
  - out_evt only, occupancy>0: occupancy −1, car_out_pulse=1.
  - out_evt only, occupancy==0: occupancy held at 0, car_out_pulse=1, underflow_err set.
  - in_evt and out_evt in the same cycle: occupancy unchanged, both pulses 1, no error even when full or empty.
  - No wrap-around in either direction.
- free_spaces, lot_full and entry_allow are registered and update on the same edge as occupancy.
- Error flags:
  - Cleared by err_clr on the next edge.
  - If set and clear coincide, set wins.
- Display:
  - Binary-to-two-digit decimal conversion of free_spaces, registered one cycle after free_spaces.
  - Digit encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - HEX_1 is blanked (1111111) when the tens digit is 0.
  - HEX_0 always shows a digit, including 0 when the lot is full.
- Reset asserted mid-event discards any pending filter counts and events; no pulse is emitted after reset releases unless the sensor goes through a fresh filtered rising edge.

Decomposition:
- Shared package parking_pkg holds the 7-segment digit constants, the blank code 7'b1111111, and the CAPACITY/CNT_W defaults.
- Sub-module sensor_filter contains the synchroniser, stable counter and filtered-level register, and is instantiated twice.
- Edge detect, counter and display conversion stay in the top module.

Test Plan:
- Reset, then idle for 20 cycles → occupancy=0, free=60, HEX_1=0000010, HEX_0=1000000, entry_allow=1, no pulses.
- gate_open=1 and sensor_exit held high for 10 cycles → one car_in_pulse at cycle 7 after the raw edge; occupancy=1, free=59, HEX_1=0010010, HEX_0=0010000.
- sensor_exit toggled every 2 cycles for 20 cycles (bounce, FILTER_CYCLES=4) → no pulse, occupancy unchanged; sensor_exit high while gate_open=0 → no count.
- Drive 60 entries → lot_full=1, entry_allow=0, HEX_1=1111111, HEX_0=1000000; a 61st entry → occupancy stays 60, overflow_err=1; err_clr → overflow_err=0.
- Empty lot plus a lane_out pass → occupancy stays 0, underflow_err=1, car_out_pulse=1.
- Occupancy=60 with simultaneous filtered in/out edges → occupancy stays 60, both pulses high, no error; reset_n pulsed low mid-filter → all outputs return to their reset values immediately, no spurious pulse afterwards.
